digit_display_arbiter: RTL and testbench

//  Shares the 4-digit 7-segment display driver between NREQ requesters (clock, counter, message

---
 rtl/digit_display_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_digit_display_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/digit_display_arbiter.sv
// digit_display_arbiter: round-robin sharing of one 4-digit 7-segment driver between requesters.
// Each owner is shown for a minimum hold time, with an optional blank gap between owners.
module digit_display_arbiter #(
    parameter int unsigned NREQ        = 3,
    parameter int unsigned HOLD_CYCLES = 5_000_000,
    parameter int unsigned GAP_CYCLES  = 1000,
    parameter int unsigned CW          = 24
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NREQ-1:0]      i_req,
    input  logic [16*NREQ-1:0]   i_req_digits,
    output logic [NREQ-1:0]      o_gnt,
    output logic [2:0]           o_active_id,
    output logic                 o_busy,
    output logic [3:0]           o_digit1,
    output logic [3:0]           o_digit2,
    output logic [3:0]           o_digit3,
    output logic [3:0]           o_digit4
);

    localparam int unsigned   HOLD_EFF  = (HOLD_CYCLES == 0) ? 1 : HOLD_CYCLES;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_EFF - 1);
    localparam logic [CW-1:0] GAP_LOAD  = (GAP_CYCLES == 0) ? '0 : CW'(GAP_CYCLES - 1);
    localparam logic [3:0]    NREQ_W    = 4'(NREQ);
    localparam logic [15:0]   BLANK     = 16'hFFFF;

    typedef enum logic [1:0] {
        StIdle,
        StShow,
        StGap
    } state_t;

    state_t            r_state;
    logic [NREQ-1:0]   r_gnt;
    logic [2:0]        r_active_id;
    logic [2:0]        r_ptr;
    logic [CW-1:0]     r_cnt;
    logic [15:0]       r_digits;

    state_t            w_state_nxt;
    logic [NREQ-1:0]   w_gnt_nxt;
    logic [2:0]        w_active_id_nxt;
    logic [2:0]        w_ptr_nxt;
    logic [CW-1:0]     w_cnt_nxt;
    logic [15:0]       w_digits_nxt;

    logic              w_found;
    logic [2:0]        w_winner;
    logic [3:0]        w_idx;
    logic [3:0]        w_win_inc;
    logic [2:0]        w_win_ptr;
    logic [NREQ-1:0]   w_win_onehot;
    logic [15:0]       w_win_digits;
    logic [15:0]       w_own_digits;
    logic              w_own_req;
    logic              w_other_req;
    logic [CW-1:0]     w_cnt_dec;

    // Round-robin search: first requester at or after r_ptr, wrapping at NREQ.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, r_ptr} + 4'(k);
            if (w_idx >= NREQ_W) begin
                w_idx = w_idx - NREQ_W;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!w_found && (w_idx == 4'(i)) && i_req[i]) begin
                    w_found  = 1'b1;
                    w_winner = 3'(i);
                end
            end
        end
    end

    always_comb begin
        w_win_onehot = '0;
        w_win_digits = BLANK;
        w_own_digits = BLANK;
        for (int i = 0; i < NREQ; i++) begin
            w_win_onehot[i] = (w_winner == 3'(i));
            if (w_winner == 3'(i)) begin
                w_win_digits = i_req_digits[16*i +: 16];
            end
            if (r_active_id == 3'(i)) begin
                w_own_digits = i_req_digits[16*i +: 16];
            end
        end
    end

    // r_gnt is one-hot on the owner while showing, so these split req into own/other.
    assign w_own_req   = |(i_req & r_gnt);
    assign w_other_req = |(i_req & ~r_gnt);

    assign w_win_inc = {1'b0, w_winner} + 4'd1;
    assign w_win_ptr = (w_win_inc >= NREQ_W) ? 3'd0 : w_win_inc[2:0];
    assign w_cnt_dec = (r_cnt != '0) ? (r_cnt - CW'(1)) : '0;

    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = r_gnt;
        w_active_id_nxt = r_active_id;
        w_ptr_nxt       = r_ptr;
        w_cnt_nxt       = w_cnt_dec;
        w_digits_nxt    = r_digits;

        unique case (r_state)
            StIdle: begin
                w_gnt_nxt    = '0;
                w_digits_nxt = BLANK;
                if (w_found) begin
                    w_state_nxt     = StShow;
                    w_gnt_nxt       = w_win_onehot;
                    w_active_id_nxt = w_winner;
                    w_ptr_nxt       = w_win_ptr;
                    w_cnt_nxt       = HOLD_LOAD;
                    w_digits_nxt    = w_win_digits;
                end
            end

            StShow: begin
                if (w_own_req) begin
                    w_digits_nxt = w_own_digits;
                end
                if (r_cnt == '0) begin
                    if (w_other_req) begin
                        w_gnt_nxt    = '0;
                        w_digits_nxt = BLANK;
                        if (GAP_CYCLES == 0) begin
                            w_state_nxt = StIdle;
                        end else begin
                            w_state_nxt = StGap;
                            w_cnt_nxt   = GAP_LOAD;
                        end
                    end else if (w_own_req) begin
                        w_cnt_nxt = HOLD_LOAD;
                    end else begin
                        w_state_nxt  = StIdle;
                        w_gnt_nxt    = '0;
                        w_digits_nxt = BLANK;
                    end
                end
            end

            StGap: begin
                w_gnt_nxt    = '0;
                w_digits_nxt = BLANK;
                if (r_cnt == '0) begin
                    if (w_found) begin
                        w_state_nxt     = StShow;
                        w_gnt_nxt       = w_win_onehot;
                        w_active_id_nxt = w_winner;
                        w_ptr_nxt       = w_win_ptr;
                        w_cnt_nxt       = HOLD_LOAD;
                        w_digits_nxt    = w_win_digits;
                    end else begin
                        w_state_nxt = StIdle;
                    end
                end
            end

            default: begin
                w_state_nxt  = StIdle;
                w_gnt_nxt    = '0;
                w_digits_nxt = BLANK;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_gnt       <= '0;
            r_active_id <= '0;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_digits    <= BLANK;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_active_id <= w_active_id_nxt;
            r_ptr       <= w_ptr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_digits    <= w_digits_nxt;
        end
    end

    assign o_gnt       = r_gnt;
    assign o_active_id = r_active_id;
    assign o_busy      = (r_state != StIdle);
    assign o_digit1    = r_digits[15:12];
    assign o_digit2    = r_digits[11:8];
    assign o_digit3    = r_digits[7:4];
    assign o_digit4    = r_digits[3:0];

endmodule

// File: tb/tb_digit_display_arbiter.sv
// Directed bench for digit_display_arbiter: HOLD=4 with GAP=2 (dut) and GAP=0 (dut_z).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_digit_display_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req, req_z;
    logic [47:0] rd, rd_z;
    logic [2:0]  gnt, gnt_z, aid, aid_z;
    logic        busy, busy_z;
    logic [3:0]  d1, d2, d3, d4, z1, z2, z3, z4;
    logic [15:0] dig, dig_z;
    int          n_checks;
    int          n_fail;

    assign dig   = {d1, d2, d3, d4};
    assign dig_z = {z1, z2, z3, z4};

    digit_display_arbiter #(
        .NREQ(3), .HOLD_CYCLES(4), .GAP_CYCLES(2), .CW(24)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_digits(rd),
        .o_gnt(gnt), .o_active_id(aid), .o_busy(busy),
        .o_digit1(d1), .o_digit2(d2), .o_digit3(d3), .o_digit4(d4)
    );

    digit_display_arbiter #(
        .NREQ(3), .HOLD_CYCLES(4), .GAP_CYCLES(0), .CW(24)
    ) dut_z (
        .i_clk(clk), .i_rst(rst), .i_req(req_z), .i_req_digits(rd_z),
        .o_gnt(gnt_z), .o_active_id(aid_z), .o_busy(busy_z),
        .o_digit1(z1), .o_digit2(z2), .o_digit3(z3), .o_digit4(z4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        req   = '0;
        req_z = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL reset_gnt got %b want 000", gnt); end
        n_checks++; if (aid !== 3'd0) begin n_fail++; $display("FAIL reset_aid got %0d want 0", aid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (dig !== 16'hFFFF) begin n_fail++; $display("FAIL reset_dig got %h want ffff", dig); end
        n_checks++; if (gnt_z !== 3'b000) begin n_fail++; $display("FAIL reset_gnt_z got %b want 000", gnt_z); end
        n_checks++; if (dig_z !== 16'hFFFF) begin n_fail++; $display("FAIL reset_dig_z got %h want ffff", dig_z); end
    endtask

    // Single requester: first-edge grant, renewal without glitch, 1-cycle digit latency.
    task automatic test_single();
        logic [15:0] exp_d;
        do_reset();
        rd[15:0] = 16'h1234;
        req      = 3'b001;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            exp_d = (n >= 4) ? 16'h5678 : 16'h1234;
            n_checks++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL single_gnt n=%0d got %b want 001", n, gnt); end
            n_checks++; if (dig !== exp_d) begin n_fail++; $display("FAIL single_dig n=%0d got %h want %h", n, dig, exp_d); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy n=%0d got %b want 1", n, busy); end
            if (n == 3) rd[15:0] = 16'h5678;
        end
    endtask

    // All three requesting: owners 0,1,2,0, four show cycles then two blank gap cycles.
    task automatic test_round_robin();
        logic [2:0]  exp_g;
        logic [15:0] exp_d;
        int          slot;
        int          phase;
        do_reset();
        rd  = {16'h3333, 16'h2222, 16'h1111};
        req = 3'b111;
        for (int n = 0; n < 22; n++) begin
            @(negedge clk);
            slot  = n / 6;
            phase = n % 6;
            if (phase < 4) begin
                exp_g = 3'b001 << (slot % 3);
                case (slot % 3)
                    0:       exp_d = 16'h1111;
                    1:       exp_d = 16'h2222;
                    default: exp_d = 16'h3333;
                endcase
            end else begin
                exp_g = 3'b000;
                exp_d = 16'hFFFF;
            end
            n_checks++; if (gnt !== exp_g) begin n_fail++; $display("FAIL rr_gnt n=%0d got %b want %b", n, gnt, exp_g); end
            n_checks++; if (dig !== exp_d) begin n_fail++; $display("FAIL rr_dig n=%0d got %h want %h", n, dig, exp_d); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rr_busy n=%0d got %b want 1", n, busy); end
        end
    endtask

    // Owner 1 drops its request mid-hold: digits freeze, hold completes, then idle.
    task automatic test_owner_drop();
        do_reset();
        rd[31:16] = 16'h9876;
        req       = 3'b010;
        @(negedge clk);
        n_checks++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL drop_gnt1 got %b want 010", gnt); end
        n_checks++; if (aid !== 3'd1) begin n_fail++; $display("FAIL drop_aid1 got %0d want 1", aid); end
        n_checks++; if (dig !== 16'h9876) begin n_fail++; $display("FAIL drop_dig1 got %h want 9876", dig); end
        rd[31:16] = 16'h4321;
        @(negedge clk);
        n_checks++; if (dig !== 16'h4321) begin n_fail++; $display("FAIL drop_dig2 got %h want 4321", dig); end
        req       = 3'b000;
        rd[31:16] = 16'h5555;
        for (int n = 3; n <= 4; n++) begin
            @(negedge clk);
            n_checks++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL drop_gnt n=%0d got %b want 010", n, gnt); end
            n_checks++; if (dig !== 16'h4321) begin n_fail++; $display("FAIL drop_frozen n=%0d got %h want 4321", n, dig); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL drop_busy n=%0d got %b want 1", n, busy); end
        end
        @(negedge clk);
        n_checks++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL drop_gnt_end got %b want 000", gnt); end
        n_checks++; if (dig !== 16'hFFFF) begin n_fail++; $display("FAIL drop_dig_end got %h want ffff", dig); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_busy_end got %b want 0", busy); end
        n_checks++; if (aid !== 3'd1) begin n_fail++; $display("FAIL drop_aid_end got %0d want 1", aid); end
    endtask

    // req2 rises during owner 0's hold: full hold, gap, then owner 2 (digits >9 passed through).
    task automatic test_no_preempt();
        do_reset();
        rd  = {16'h0C0D, 16'h0000, 16'h1234};
        req = 3'b001;
        @(negedge clk);
        n_checks++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL np_gnt1 got %b want 001", gnt); end
        req = 3'b101;
        for (int n = 2; n <= 4; n++) begin
            @(negedge clk);
            n_checks++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL np_hold n=%0d got %b want 001", n, gnt); end
            n_checks++; if (dig !== 16'h1234) begin n_fail++; $display("FAIL np_dig n=%0d got %h want 1234", n, dig); end
        end
        for (int n = 5; n <= 6; n++) begin
            @(negedge clk);
            n_checks++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL np_gap n=%0d got %b want 000", n, gnt); end
            n_checks++; if (dig !== 16'hFFFF) begin n_fail++; $display("FAIL np_gapdig n=%0d got %h want ffff", n, dig); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL np_gapbusy n=%0d got %b want 1", n, busy); end
        end
        @(negedge clk);
        n_checks++; if (gnt !== 3'b100) begin n_fail++; $display("FAIL np_gnt2 got %b want 100", gnt); end
        n_checks++; if (aid !== 3'd2) begin n_fail++; $display("FAIL np_aid2 got %0d want 2", aid); end
        n_checks++; if (dig !== 16'h0C0D) begin n_fail++; $display("FAIL np_dig2 got %h want 0c0d", dig); end
    endtask

    // Asynchronous reset mid-SHOW and mid-GAP; pointer restarts at 0.
    task automatic test_reset_mid();
        do_reset();
        rd  = {16'h7777, 16'h2222, 16'h1111};
        req = 3'b100;
        @(negedge clk);
        n_checks++; if (gnt !== 3'b100) begin n_fail++; $display("FAIL rm_show_pre got %b want 100", gnt); end
        rst = 1'b1;
        #1;
        n_checks++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL rm_show_gnt got %b want 000", gnt); end
        n_checks++; if (dig !== 16'hFFFF) begin n_fail++; $display("FAIL rm_show_dig got %h want ffff", dig); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_show_busy got %b want 0", busy); end
        n_checks++; if (aid !== 3'd0) begin n_fail++; $display("FAIL rm_show_aid got %0d want 0", aid); end
        @(negedge clk);
        rst = 1'b0;
        req = 3'b110;
        @(negedge clk);
        n_checks++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL rm_first got %b want 010", gnt); end
        n_checks++; if (aid !== 3'd1) begin n_fail++; $display("FAIL rm_first_aid got %0d want 1", aid); end
        repeat (4) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rm_gap_pre_busy got %b want 1", busy); end
        n_checks++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL rm_gap_pre_gnt got %b want 000", gnt); end
        rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_gap_busy got %b want 0", busy); end
        n_checks++; if (aid !== 3'd0) begin n_fail++; $display("FAIL rm_gap_aid got %0d want 0", aid); end
        n_checks++; if (dig !== 16'hFFFF) begin n_fail++; $display("FAIL rm_gap_dig got %h want ffff", dig); end
        @(negedge clk);
        rst = 1'b0;
        req = 3'b000;
    endtask

    // GAP_CYCLES=0: owner 0, exactly one cycle with no grant, then owner 1.
    task automatic test_zero_gap();
        do_reset();
        rd_z  = {16'h0000, 16'h2222, 16'h1111};
        req_z = 3'b011;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            n_checks++; if (gnt_z !== 3'b001) begin n_fail++; $display("FAIL zg_gnt0 n=%0d got %b want 001", n, gnt_z); end
        end
        @(negedge clk);
        n_checks++; if (gnt_z !== 3'b000) begin n_fail++; $display("FAIL zg_idle_gnt got %b want 000", gnt_z); end
        n_checks++; if (dig_z !== 16'hFFFF) begin n_fail++; $display("FAIL zg_idle_dig got %h want ffff", dig_z); end
        n_checks++; if (busy_z !== 1'b0) begin n_fail++; $display("FAIL zg_idle_busy got %b want 0", busy_z); end
        @(negedge clk);
        n_checks++; if (gnt_z !== 3'b010) begin n_fail++; $display("FAIL zg_gnt1 got %b want 010", gnt_z); end
        n_checks++; if (aid_z !== 3'd1) begin n_fail++; $display("FAIL zg_aid1 got %0d want 1", aid_z); end
        n_checks++; if (dig_z !== 16'h2222) begin n_fail++; $display("FAIL zg_dig1 got %h want 2222", dig_z); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        req      = '0;
        req_z    = '0;
        rd       = {48{1'b1}};
        rd_z     = {48{1'b1}};
        test_reset();
        test_single();
        test_round_robin();
        test_owner_drop();
        test_no_preempt();
        test_reset_mid();
        test_zero_gap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
